// File: rtl/clk_rst_pkg.sv
// Shared state encoding and default constants for the clock/reset controller.
package clk_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int CLK_DIV_DEF       = 25;
    localparam int STABLE_CYCLES_DEF = 1024;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Both flops clear asynchronously with rst_n.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_rst_ctrl.sv
// PLL-lock qualified system reset and CPU clock-enable generator.
// Define CPU_TURBO_EN to add the turbo port (undivided CPU enable).
module clk_rst_ctrl
    import clk_rst_pkg::*;
#(
    parameter int CLK_DIV       = CLK_DIV_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic clk25,
    input  logic rst_n,
    input  logic pll_lock,
    input  logic sw_rst_req,
`ifdef CPU_TURBO_EN
    input  logic turbo,
`endif
    output logic sys_rst_n,
    output logic cpu_clken,
    output logic ready
);

    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);

    logic          lock_s;
    state_t        state;
    state_t        nxt;
    logic [SW-1:0] stab_cnt;
    logic [DW-1:0] div_cnt;
    logic          in_run;

    sync_2ff u_lock_sync (
        .clk   (clk25),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // Lock loss is checked first everywhere so it wins over sw_rst_req.
    always_comb begin
        nxt = state;
        unique case (state)
            WAIT_LOCK: if (lock_s) nxt = STABILIZE;
            STABILIZE: begin
                if (!lock_s)
                    nxt = WAIT_LOCK;
                else if (stab_cnt == STAB_LAST)
                    nxt = RUN;
            end
            RUN: begin
                if (!lock_s)
                    nxt = WAIT_LOCK;
                else if (sw_rst_req)
                    nxt = STABILIZE;
            end
            default: nxt = WAIT_LOCK;
        endcase
    end

    // Divider only runs while staying in RUN, so it clears with sys_rst_n.
    assign in_run = (state == RUN) && (nxt == RUN);
    assign ready  = sys_rst_n;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAIT_LOCK;
            stab_cnt <= '0;
            sys_rst_n <= 1'b0;
        end else begin
            state     <= nxt;
            sys_rst_n <= (nxt == RUN);
            if ((state == STABILIZE) && lock_s)
                stab_cnt <= stab_cnt + 1'b1;
            else
                stab_cnt <= '0;
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            cpu_clken <= 1'b0;
        end else if (!in_run) begin
            div_cnt   <= '0;
            cpu_clken <= 1'b0;
        end else begin
`ifdef CPU_TURBO_EN
            if (turbo) begin
                div_cnt   <= '0;
                cpu_clken <= 1'b1;
            end else
`endif
            begin
                cpu_clken <= (div_cnt == DIV_LAST);
                if (div_cnt == DIV_LAST)
                    div_cnt <= '0;
                else
                    div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/clk_rst_ctrl.md
CLK_RST_CTRL -- requirements
Module: clk_rst_ctrl

Interface
- REQ-001: Parameter CLK_DIV, default 25, is the cpu_clken division ratio from clk25 (25 MHz to 1 MHz); legal range 2..256.
- REQ-002: Parameter STABLE_CYCLES, default 1024, is the number of clk25 cycles that lock must hold before reset release; legal range 2..65536.
- REQ-003: clk25  input  1  system clock from the PLL global output; all flops are clocked on its rising edge.
- REQ-004: rst_n  input  1  asynchronous, active-low reset; the same net drives the PLL RESETB.
- REQ-005: pll_lock  input  1  PLL LOCK flag, asynchronous to clk25.
- REQ-006: sw_rst_req  input  1  synchronous, active-high request from the keyboard reset key.
- REQ-007: turbo  input  1  selects undivided CPU rate; the port is present only when CPU_TURBO_EN is defined.
- REQ-008: sys_rst_n  output  1  system reset; assertion is asynchronous, deassertion is synchronous to clk25.
- REQ-009: cpu_clken  output  1  single-cycle CPU clock-enable strobe.
- REQ-010: ready  output  1  high while in RUN; equals sys_rst_n.

Function
- REQ-011: pll_lock SHALL pass through a 2-flop synchronizer to form lock_s; lock_s rises on the 2nd rising edge after pll_lock rises.
- REQ-012: The FSM SHALL have three states: WAIT_LOCK, STABILIZE and RUN.
- REQ-013: WAIT_LOCK -> STABILIZE on the edge where lock_s=1; the stability counter is cleared to 0 on that edge.
- REQ-014: STABILIZE: the counter increments each cycle; the FSM moves to RUN on the edge where count==STABLE_CYCLES-1 and lock_s=1.
- REQ-015: STABILIZE -> WAIT_LOCK whenever lock_s=0; the counter clears; this rule has priority over REQ-014.
- REQ-016: RUN -> WAIT_LOCK when lock_s=0; RUN -> STABILIZE, with the counter cleared, when sw_rst_req=1 and lock_s=1.
- REQ-017: Lock loss SHALL take priority over sw_rst_req when both occur in the same cycle.
- REQ-018: sw_rst_req SHALL be ignored in WAIT_LOCK and STABILIZE.
- REQ-019: sys_rst_n is a register that loads (next_state==RUN); it rises on the same edge the FSM enters RUN and falls on the same edge the FSM leaves RUN.
- REQ-020: The reset-release latency SHALL be STABLE_CYCLES+3 edges, counting the first edge that samples pll_lock=1 as edge 1.
- REQ-021: The divider counter, width $clog2(CLK_DIV), SHALL be held at 0 outside RUN, count 0..CLK_DIV-1 in RUN and wrap to 0.
- REQ-022: cpu_clken is registered; it is high for exactly one cycle after each edge where the divider counter equals CLK_DIV-1 in RUN, giving period CLK_DIV.
- REQ-023: The first cpu_clken pulse SHALL occur CLK_DIV edges after RUN entry; cpu_clken SHALL never be high while sys_rst_n=0.
- REQ-024: When leaving RUN, the divider counter and cpu_clken SHALL clear on the same edge as sys_rst_n.

Reset
- REQ-025: While rst_n=0, the synchronizer flops, FSM (WAIT_LOCK), stability counter, divider counter, sys_rst_n, cpu_clken and ready SHALL all be 0 asynchronously.
- REQ-026: After rst_n deasserts, operation SHALL start from WAIT_LOCK; there is no combinational path from rst_n to any output other than the asynchronous clear.

Configuration
- REQ-027: With CPU_TURBO_EN defined, turbo=1 in RUN SHALL hold cpu_clken high every cycle, starting the edge after turbo is sampled high.
- REQ-028: With CPU_TURBO_EN defined, turbo=0 SHALL restart division with the divider counter at 0.
- REQ-029: Without CPU_TURBO_EN, the turbo port and its logic SHALL be absent, and behaviour SHALL match REQ-021..REQ-024.

Structure
- REQ-030: Package clk_rst_pkg SHALL hold the state enum (WAIT_LOCK=2'd0, STABILIZE=2'd1, RUN=2'd2) and the default constants CLK_DIV_DEF=25 and STABLE_CYCLES_DEF=1024.
- REQ-031: The synchronizer SHALL be sub-module sync_2ff (1-bit, async active-low clear), instantiated once for pll_lock.

Verification
- REQ-032: Parameters STABLE_CYCLES=16, CLK_DIV=25; pll_lock rises and is held -> sys_rst_n and ready rise at edge 19; first cpu_clken at edge 44, then every 25 cycles.
- REQ-033: pll_lock drops for 3 cycles while count=10 in STABILIZE -> FSM returns to WAIT_LOCK and the counter clears; release occurs a full 19 edges after lock returns.
- REQ-034: In RUN, pll_lock drops -> sys_rst_n and cpu_clken are 0 three edges later; the divider counter reads 0.
- REQ-035: In RUN, a 1-cycle sw_rst_req -> sys_rst_n low for 16 cycles, then high; no cpu_clken pulse while it is low.
- REQ-036: sw_rst_req and lock loss reach the FSM in the same cycle -> next state is WAIT_LOCK.
- REQ-037: rst_n asserted mid-RUN between clock edges -> all outputs 0 immediately without waiting for a clock edge.
- REQ-038: With CPU_TURBO_EN defined, turbo=1 in RUN -> cpu_clken constantly high; turbo=0 -> next pulse 25 cycles later.
